// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: FSM state
//                encoding, access-size codes and the latency counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    // Width of the read-latency counter (MEM_LAT legal range 1..15)
    localparam int unsigned LAT_W = 4;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        MERGE = ST_MERGE,
        WRITE = ST_WRITE,
        RESP  = ST_RESP
    } lsu_state_t;

    // Access size codes (2'b11 is illegal)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ============================================================================
//  Module      : lsu_if
//  Description : Request/response and data-memory signals of the load/store
//                unit. The slave modport is the LSU's view; master is the
//                environment (execute stage plus data RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        rspValid;
    logic [31:0] rspRData;
    logic        rspErr;
    logic        memREn;
    logic        memWEn;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memRData,
        output reqReady, rspValid, rspRData, rspErr, memREn, memWEn, memAddr, memWData
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memRData,
        input  reqReady, rspValid, rspRData, rspErr, memREn, memWEn, memAddr, memWData
    );
endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational lane handling. Extracts and sign/zero-extends
//                the addressed byte/half of a loaded word, and merges a
//                sub-word store value into the old memory word.
//                Sub-word lanes exist only when LSU_SUBWORD_EN is defined;
//                otherwise the word passes straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

`ifdef LSU_SUBWORD_EN
    logic [4:0]  w_shift;
    logic [15:0] w_lane;
    logic [31:0] w_mask;

    // Lane select/extend for loads and lane merge for stores; half accesses
    // are aligned so the same byte-offset shift covers both sizes
    always_comb begin
        w_shift  = {i_offset, 3'b000};
        w_lane   = 16'(i_word >> w_shift);
        w_mask   = '0;
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load   = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
                w_mask   = 32'h0000_00FF << w_shift;
                o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
            end
            SZ_H: begin
                o_load   = {{16{i_signed & w_lane[15]}}, w_lane};
                w_mask   = 32'h0000_FFFF << w_shift;
                o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
            end
            default: ;
        endcase
    end
`else
    logic w_unused;

    // Word-only build: no lane manipulation
    assign o_load   = i_word;
    assign o_merged = i_wdata;
    assign w_unused = ^{i_size, i_signed, i_offset};
`endif

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator. Accepts one load/store at a time,
//                checks it, sequences RAM strobes through an FSM, waits
//                MEM_LAT cycles for read data and returns a one-cycle
//                response. Macro LSU_SUBWORD_EN enables byte/half accesses
//                (stores via read-modify-write).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    lsu_state_t       r_state;
    lsu_state_t       w_next;
    logic [LAT_W-1:0] r_cnt;
    logic             r_write;
    logic             r_signed;
    logic             r_err;
    logic [1:0]       r_size;
    logic [1:0]       r_off;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_word;
    logic [31:0]      r_rdata;
    logic             w_req_err;
    logic             w_last;
    logic [31:0]      w_align_word;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;

    assign w_last = (r_cnt == LAT_W'(MEM_LAT));

    // Raw RAM data feeds load extraction; the captured word feeds the merge
    assign w_align_word = (r_state == READ) ? bus.memRData : r_word;

    lsu_lane_align u_align (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_offset (r_off),
        .i_word   (w_align_word),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

`ifndef LSU_SUBWORD_EN
    logic w_unused_merged;
    assign w_unused_merged = ^w_merged;
`endif

    // Request legality: illegal size, misalignment, address beyond the RAM
    always_comb begin
        w_req_err = 1'b0;
        if (bus.reqSize == 2'b11)                                w_req_err = 1'b1;
        if (bus.reqSize == SZ_H && bus.reqAddr[0])               w_req_err = 1'b1;
        if (bus.reqSize == SZ_W && bus.reqAddr[1:0] != 2'b00)    w_req_err = 1'b1;
        if (bus.reqAddr[31:ADDR_W+2] != '0)                      w_req_err = 1'b1;
`ifndef LSU_SUBWORD_EN
        if (bus.reqSize == SZ_B || bus.reqSize == SZ_H)          w_req_err = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; errors bypass memory straight to the response
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.reqValid) begin
                    if (w_req_err)                              w_next = RESP;
                    else if (bus.reqWrite && bus.reqSize == SZ_W) w_next = WRITE;
                    else                                        w_next = READ;
                end
            end
            READ: begin
                if (w_last) begin
`ifdef LSU_SUBWORD_EN
                    w_next = r_write ? MERGE : RESP;
`else
                    w_next = RESP;
`endif
                end
            end
`ifdef LSU_SUBWORD_EN
            MERGE:   w_next = WRITE;
`endif
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latch, latency counter, read capture and store-word merge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= '0;
            r_off    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.reqValid) begin
                        r_cnt    <= LAT_W'(1);
                        r_write  <= bus.reqWrite;
                        r_signed <= bus.reqSigned;
                        r_size   <= bus.reqSize;
                        r_off    <= bus.reqAddr[1:0];
                        r_wdata  <= bus.reqWData;
                        r_addr   <= 32'(bus.reqAddr[ADDR_W+1:2]);
                        r_err    <= w_req_err;
                        r_rdata  <= '0;
                    end
                end
                READ: begin
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_word <= bus.memRData;
                        if (!r_write) r_rdata <= w_load;
                    end else begin
                        r_cnt <= r_cnt + LAT_W'(1);
                    end
                end
`ifdef LSU_SUBWORD_EN
                MERGE:   r_wdata <= w_merged;
`endif
                default: ;
            endcase
        end
    end

    assign bus.reqReady = (r_state == IDLE);
    assign bus.memREn   = (r_state == READ);
    assign bus.memWEn   = (r_state == WRITE);
    assign bus.rspValid = (r_state == RESP);
    assign bus.rspErr   = bus.rspValid & r_err;
    assign bus.rspRData = bus.rspValid ? r_rdata : '0;
    assign bus.memAddr  = r_addr;
    assign bus.memWData = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench. Two LSUs (MEM_LAT 1 and 3) receive the
//                same directed requests; each has its own RAM model and a
//                cycle-timeline reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  t_valid = 2'b00;
    logic        t_write = 1'b0;
    logic [1:0]  t_size = 2'b10;
    logic        t_signed = 1'b0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          started = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;

        lsu_if bus ();

        load_store_unit #(.MEM_LAT(L), .ADDR_W(8)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.reqValid  = t_valid[g];
        assign bus.reqWrite  = t_write;
        assign bus.reqSize   = t_size;
        assign bus.reqSigned = t_signed;
        assign bus.reqAddr   = t_addr;
        assign bus.reqWData  = t_wdata;

        // RAM: data is valid only in the L-th cycle of a read strobe
        logic [31:0] ram [256] = '{default: 32'h0};
        int          ren_run = 0;
        always @(posedge clk) begin
            if (bus.memWEn) ram[bus.memAddr[7:0]] <= bus.memWData;
            ren_run <= bus.memREn ? ren_run + 1 : 0;
        end
        assign bus.memRData = (bus.memREn && ren_run == L - 1) ? ram[bus.memAddr[7:0]] : 32'hBAD0_BAD0;

        // Reference model: per request, a timeline of cycles after accept
        logic [31:0] mm [256] = '{default: 32'h0};
        bit          m_busy = 1'b0;
        bit          m_rd = 1'b0;
        bit          m_err = 1'b0;
        int          m_t = 0, m_rspc = 0, m_wcyc = 0;
        logic [31:0] m_addr = '0, m_wexp = '0, m_rexp = '0;

        always @(posedge clk) begin
            logic [31:0] a, w, mask;
            int sh;
            if (!rst_n) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_t == m_rspc) m_busy = 1'b0;
                else               m_t = m_t + 1;
            end else if (t_valid[g]) begin
                a = t_addr;
                sh = 8 * int'(a[1:0]);
                m_busy = 1'b1; m_t = 1; m_rd = 1'b0; m_wcyc = 0;
                m_rexp = '0; m_wexp = '0;
                m_addr = {24'd0, a[9:2]};
                m_err = (t_size == 2'd3) || (t_size == 2'd1 && a[0]) ||
                        (t_size == 2'd2 && a[1:0] != 2'd0) || (a > 32'h3FF);
`ifndef LSU_SUBWORD_EN
                if (t_size < 2'd2) m_err = 1'b1;
`endif
                if (m_err) begin
                    m_rspc = 1;
                end else if (!t_write) begin
                    m_rd = 1'b1; m_rspc = L + 1;
                    w = mm[a[9:2]] >> sh;
                    if (t_size == 2'd0)      m_rexp = {{24{t_signed & w[7]}}, w[7:0]};
                    else if (t_size == 2'd1) m_rexp = {{16{t_signed & w[15]}}, w[15:0]};
                    else                     m_rexp = w;
                end else if (t_size == 2'd2) begin
                    m_wcyc = 1; m_rspc = 2;
                    m_wexp = t_wdata; mm[a[9:2]] = t_wdata;
                end else begin
                    m_rd = 1'b1; m_wcyc = L + 2; m_rspc = L + 3;
                    mask = ((t_size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                    m_wexp = (mm[a[9:2]] & ~mask) | ((t_wdata << sh) & mask);
                    mm[a[9:2]] = m_wexp;
                end
            end
        end

        // Compare DUT against the model every cycle
        always @(negedge clk) begin
            bit e_ren, e_wen, e_rv;
            if (started) begin
                e_ren = m_busy && m_rd && m_t <= L;
                e_wen = m_busy && m_wcyc != 0 && m_t == m_wcyc;
                e_rv  = m_busy && m_t == m_rspc;
                chk($sformatf("L%0d reqReady", L), bus.reqReady, !m_busy);
                chk($sformatf("L%0d memREn", L),   bus.memREn, e_ren);
                chk($sformatf("L%0d memWEn", L),   bus.memWEn, e_wen);
                chk($sformatf("L%0d rspValid", L), bus.rspValid, e_rv);
                if (e_ren || e_wen) chk($sformatf("L%0d memAddr", L), bus.memAddr, m_addr);
                if (e_wen) chk($sformatf("L%0d memWData", L), bus.memWData, m_wexp);
                if (e_rv) begin
                    chk($sformatf("L%0d rspErr", L), bus.rspErr, m_err);
                    chk($sformatf("L%0d rspRData", L), bus.rspRData, m_rexp);
                end
            end
        end

        // Strobe exclusivity
        always @(posedge clk) begin
            if (started) begin
                assert (!(bus.memREn && bus.memWEn)) else begin
                    errors++;
                    $display("FAIL L%0d strobes: memREn and memWEn both high", L);
                end
            end
        end

        // Transaction monitor for the hand-checked expectations
        int acc_cyc = 0, acc_cnt = 0, rsp_cnt = 0, strobe_cnt = 0;
        int last_lat = 0, wen_lat = 0;
        logic [31:0] last_data = '0, wen_addr = '0;
        logic last_err = 1'b0;
        always @(posedge clk) begin
            if (rst_n && t_valid[g] && bus.reqReady) begin
                acc_cyc = cyc + 1;
                acc_cnt++;
            end
        end
        always @(negedge clk) begin
            if (bus.memREn || bus.memWEn) strobe_cnt++;
            if (bus.memWEn) begin
                wen_lat  = cyc - acc_cyc + 1;
                wen_addr = bus.memAddr;
            end
            if (bus.rspValid) begin
                rsp_cnt++;
                last_data = bus.rspRData;
                last_err  = bus.rspErr;
                last_lat  = cyc - acc_cyc + 1;
            end
        end
    end

    int s0 = 0, s1 = 0;

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd);
        int c0, c1, n;
        @(negedge clk);
        t_write = w; t_size = sz; t_signed = sg; t_addr = ad; t_wdata = wd;
        c0 = g_inst[0].rsp_cnt; c1 = g_inst[1].rsp_cnt;
        s0 = g_inst[0].strobe_cnt; s1 = g_inst[1].strobe_cnt;
        t_valid = 2'b11;
        @(posedge clk);
        #1 t_valid = 2'b00;
        n = 0;
        while ((g_inst[0].rsp_cnt == c0 || g_inst[1].rsp_cnt == c1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL timeout: no response for addr %h within 40 cycles", ad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, r0, r1, c1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state: ready high, everything else low/zero
        chk("reset L1 ctl", {g_inst[0].bus.reqReady, g_inst[0].bus.memREn, g_inst[0].bus.memWEn,
                             g_inst[0].bus.rspValid, g_inst[0].bus.rspErr}, 32'h10);
        chk("reset L3 ctl", {g_inst[1].bus.reqReady, g_inst[1].bus.memREn, g_inst[1].bus.memWEn,
                             g_inst[1].bus.rspValid, g_inst[1].bus.rspErr}, 32'h10);
        chk("reset L1 data", g_inst[0].bus.memAddr | g_inst[0].bus.memWData | g_inst[0].bus.rspRData, 32'h0);
        chk("reset L3 data", g_inst[1].bus.memAddr | g_inst[1].bus.memWData | g_inst[1].bus.rspRData, 32'h0);
        rst_n = 1'b1;

        // Word store then load at 0x10
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("st L1 wen cycle", g_inst[0].wen_lat, 1);
        chk("st L1 memAddr", g_inst[0].wen_addr, 4);
        chk("st L1 rsp cycle", g_inst[0].last_lat, 2);
        chk("st L1 rspErr", g_inst[0].last_err, 0);
        chk("st L1 ram", g_inst[0].ram[4], 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("ld L1 data", g_inst[0].last_data, 32'hDEAD_BEEF);
        chk("ld L1 rsp cycle", g_inst[0].last_lat, 2);
        chk("ld L3 data", g_inst[1].last_data, 32'hDEAD_BEEF);
        chk("ld L3 rsp cycle", g_inst[1].last_lat, 4);
        chk("ld L3 ren cycles", g_inst[1].strobe_cnt - s1, 3);

        // Errors: misaligned word, out of range, illegal size
        do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
        chk("err misalign L1", g_inst[0].last_err, 1);
        chk("err misalign L1 cycle", g_inst[0].last_lat, 1);
        chk("err misalign L3 strobes", g_inst[1].strobe_cnt - s1, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        chk("err range L3", g_inst[1].last_err, 1);
        chk("err range L1 strobes", g_inst[0].strobe_cnt - s0, 0);
        do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h5);
        chk("err size L1", g_inst[0].last_err, 1);
        chk("err size L3 data", g_inst[1].last_data, 0);

`ifdef LSU_SUBWORD_EN
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h1, 32'h1234_56AA);
        chk("sb L1 ram", g_inst[0].ram[0], 32'h1122_AA44);
        chk("sb L3 ram", g_inst[1].ram[0], 32'h1122_AA44);
        chk("sb L3 err", g_inst[1].last_err, 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h1, 32'h0);
        chk("lb signed L1", g_inst[0].last_data, 32'hFFFF_FFAA);
        chk("lb signed L3", g_inst[1].last_data, 32'hFFFF_FFAA);
        do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        chk("lhu L1", g_inst[0].last_data, 32'h0000_1122);
        chk("lhu L3", g_inst[1].last_data, 32'h0000_1122);
`else
        do_req(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_00AA);
        chk("sb disabled L1 err", g_inst[0].last_err, 1);
        chk("sb disabled L3 strobes", g_inst[1].strobe_cnt - s1, 0);
        do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        chk("lh disabled L3 err", g_inst[1].last_err, 1);
`endif

        // Reset in cycle 2 of a MEM_LAT=3 load
        @(negedge clk);
        t_write = 1'b0; t_size = 2'b10; t_signed = 1'b0; t_addr = 32'h10;
        t_valid = 2'b11;
        @(posedge clk);
        #1 t_valid = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b0;
        c1 = g_inst[1].rsp_cnt;
        @(posedge clk);
        #1;
        chk("midrst L3 memREn", g_inst[1].bus.memREn, 0);
        chk("midrst L3 reqReady", g_inst[1].bus.reqReady, 1);
        chk("midrst L3 rspValid", g_inst[1].bus.rspValid, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst L3 no rsp", g_inst[1].rsp_cnt - c1, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
        chk("post-rst st L3 err", g_inst[1].last_err, 0);
        chk("post-rst st L3 ram", g_inst[1].ram[8], 32'hCAFE_F00D);

        // Back-to-back: reqValid held high for 30 cycles
        a0 = g_inst[0].acc_cnt; a1 = g_inst[1].acc_cnt;
        r0 = g_inst[0].rsp_cnt; r1 = g_inst[1].rsp_cnt;
        @(negedge clk);
        t_write = 1'b0; t_size = 2'b10; t_signed = 1'b0; t_addr = 32'h10;
        t_valid = 2'b11;
        repeat (30) @(negedge clk);
        t_valid = 2'b00;
        repeat (10) @(negedge clk);
        chk("b2b L1 accepts", g_inst[0].acc_cnt - a0, 10);
        chk("b2b L3 accepts", g_inst[1].acc_cnt - a1, 6);
        chk("b2b L1 acc=rsp", g_inst[0].rsp_cnt - r0, g_inst[0].acc_cnt - a0);
        chk("b2b L3 acc=rsp", g_inst[1].rsp_cnt - r1, g_inst[1].acc_cnt - a1);
        chk("b2b L3 data", g_inst[1].last_data, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
